// File: rtl/dsss_qpsk_mapper.sv
// dsss_qpsk_mapper
//   Spreads each input word (MSB first) with a free-running 7-bit PN sequence.
//   Each data bit and two consecutive PN chips form one QPSK symbol
//   {I[15:0], Q[15:0]}. Symbols go into a small buffer, and one symbol is
//   released per output slot of DIVIDER clock cycles.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_data          input word, SIZE_INPUT_BIT bits
//   i_valid_input   i_data valid
//   o_ready         block can take a word
//   o_data          output symbol {I, Q}, two's complement
//   o_valid_output  one-cycle strobe per output slot
//   o_underrun      one-cycle pulse when a slot carries the idle symbol (0)
//   o_fifo_level    current symbol buffer occupancy
//
// Handshake: a word transfers on a rising edge where i_valid_input and o_ready
// are both high. o_ready is registered and drops on the cycle after a transfer.
//
// Optional feature: define DSSS_QPSK_DIFF_EN to differentially encode each
// rail (tx = chip ^ previous tx) before mapping.
module dsss_qpsk_mapper #(
    parameter int                 SIZE_INPUT_BIT = 8,
    parameter int                 SPREAD         = 24,
    parameter int                 DIVIDER        = 120,
    parameter int                 FIFO_DEPTH     = 16,
    parameter logic signed [15:0] AMPLITUDE      = 16'sd8192,
    parameter logic [6:0]         PN_SEED        = 7'h7F
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]     i_data,
    input  logic                          i_valid_input,
    output logic                          o_ready,
    output logic [31:0]                   o_data,
    output logic                          o_valid_output,
    output logic                          o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int SYM_PER_BIT = SPREAD / 2;
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int BW = (SIZE_INPUT_BIT > 1) ? $clog2(SIZE_INPUT_BIT) : 1;
    localparam int CW = (SYM_PER_BIT > 1) ? $clog2(SYM_PER_BIT) : 1;
    localparam int DW = $clog2(DIVIDER);

    localparam logic [BW-1:0] LAST_BIT  = BW'(SIZE_INPUT_BIT - 1);
    localparam logic [CW-1:0] LAST_SYM  = CW'(SYM_PER_BIT - 1);
    localparam logic [DW-1:0] LAST_SLOT = DW'(DIVIDER - 1);
    localparam logic [LW:0]   FULL_LVL  = (LW + 1)'(FIFO_DEPTH);

    localparam logic signed [15:0] POS_LVL = AMPLITUDE;
    localparam logic signed [15:0] NEG_LVL = -AMPLITUDE;

    typedef enum logic {IDLE, SPREADING} state_t;

    // Exposed for checkers and debug.
    state_t                    state;
    logic [SIZE_INPUT_BIT-1:0] shreg;
    logic [BW-1:0]             bit_cnt;
    logic [CW-1:0]             sym_cnt;
    logic [6:0]                lfsr;
    logic [DW-1:0]             slot_cnt;
    logic [31:0]               mem [FIFO_DEPTH];
    logic [LW-1:0]             wr_ptr;
    logic [LW-1:0]             rd_ptr;
    logic [LW:0]               level;
    logic                      started;

    logic        full;
    logic        empty;
    logic        slot;
    logic        wr_en;
    logic        pop;
    logic        data_bit;
    logic        chip_i;
    logic        chip_q;
    logic        tx_i;
    logic        tx_q;
    logic [6:0]  lfsr_next2;
    logic [31:0] sym;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign slot     = (slot_cnt == LAST_SLOT);
    assign wr_en    = (state == SPREADING) && !full;
    assign pop      = slot && !empty;
    assign data_bit = shreg[SIZE_INPUT_BIT-1];

    // c0 is the current chip (lfsr[6]); c1 is the chip after one step, which
    // is lfsr[5]. Two steps are taken per symbol.
    assign chip_i     = data_bit ^ lfsr[6];
    assign chip_q     = data_bit ^ lfsr[5];
    assign lfsr_next2 = {lfsr[4:0], lfsr[6] ^ lfsr[5], lfsr[5] ^ lfsr[4]};

`ifdef DSSS_QPSK_DIFF_EN
    logic prev_i;
    logic prev_q;

    assign tx_i = chip_i ^ prev_i;
    assign tx_q = chip_q ^ prev_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            prev_i <= 1'b0;
            prev_q <= 1'b0;
        end else if (wr_en) begin
            prev_i <= tx_i;
            prev_q <= tx_q;
        end
    end
`else
    assign tx_i = chip_i;
    assign tx_q = chip_q;
`endif

    assign sym = {(tx_i ? NEG_LVL : POS_LVL), (tx_q ? NEG_LVL : POS_LVL)};

    // Word FSM: IDLE accepts a word, SPREADING emits one symbol per cycle
    // unless the buffer is full.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            o_ready <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            sym_cnt <= '0;
            lfsr    <= PN_SEED;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid_input && o_ready) begin
                        shreg   <= i_data;
                        bit_cnt <= '0;
                        sym_cnt <= '0;
                        state   <= SPREADING;
                        o_ready <= 1'b0;
                    end
                end
                SPREADING: begin
                    if (!full) begin
                        lfsr <= lfsr_next2;
                        if (sym_cnt == LAST_SYM) begin
                            sym_cnt <= '0;
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state   <= IDLE;
                                o_ready <= 1'b1;
                            end
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    // Buffer storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sym;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            slot_cnt       <= '0;
            started        <= 1'b0;
            o_data         <= '0;
            o_valid_output <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            slot_cnt       <= slot ? '0 : slot_cnt + 1'b1;
            o_valid_output <= 1'b0;
            o_underrun     <= 1'b0;

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (slot) begin
                if (!empty) begin
                    o_data         <= mem[rd_ptr];
                    rd_ptr         <= rd_ptr + 1'b1;
                    o_valid_output <= 1'b1;
                    started        <= 1'b1;
                end else if (started) begin
                    // Idle symbol only once real traffic has begun.
                    o_data         <= '0;
                    o_valid_output <= 1'b1;
                    o_underrun     <= 1'b1;
                end
            end
        end
    end

    assign o_fifo_level = level;

endmodule

// File: tb/tb_dsss_qpsk_mapper.sv
// Testbench for dsss_qpsk_mapper with SPREAD=2, DIVIDER=4, FIFO_DEPTH=16,
// SIZE_INPUT_BIT=8. Define DSSS_QPSK_DIFF_EN for both files to cover the
// differential build.
module tb_dsss_qpsk_mapper;

    localparam int W     = 8;
    localparam int SPR   = 2;
    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int AMP   = 8192;
    localparam int SYMS  = W * SPR / 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [W-1:0] data;
    logic        valid;
    logic        ready;
    logic [31:0] odata;
    logic        ovalid;
    logic        underrun;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    dsss_qpsk_mapper #(
        .SIZE_INPUT_BIT(W),
        .SPREAD        (SPR),
        .DIVIDER       (DIV),
        .FIFO_DEPTH    (DEPTH),
        .AMPLITUDE     (16'sd8192),
        .PN_SEED       (7'h7F)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_data        (data),
        .i_valid_input (valid),
        .o_ready       (ready),
        .o_data        (odata),
        .o_valid_output(ovalid),
        .o_underrun    (underrun),
        .o_fifo_level  (level)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    int          m_lfsr;
    logic        m_prev_i;
    logic        m_prev_q;

    task automatic next_chip(output int c);
        c = (m_lfsr >> 6) & 1;
        m_lfsr = ((m_lfsr << 1) & 'h7F) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
    endtask

    task automatic model_push(input logic [W-1:0] w);
        int c0, c1, b, ti, tq;
        logic [15:0] vi, vq;
        for (int k = W - 1; k >= 0; k--) begin
            b = int'(w[k]);
            for (int j = 0; j < SPR / 2; j++) begin
                next_chip(c0);
                next_chip(c1);
                ti = b ^ c0;
                tq = b ^ c1;
`ifdef DSSS_QPSK_DIFF_EN
                ti = ti ^ int'(m_prev_i);
                tq = tq ^ int'(m_prev_q);
                m_prev_i = ti[0];
                m_prev_q = tq[0];
`endif
                vi = (ti != 0) ? 16'(-AMP) : 16'(AMP);
                vq = (tq != 0) ? 16'(-AMP) : 16'(AMP);
                exp_q.push_back({vi, vq});
            end
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    int          edge_n;
    int          xfer_edge;
    logic        started;
    logic        pending_xfer;
    logic [31:0] last_data;
    int          n_real;
    logic [31:0] first_sym;
    logic [31:0] second_sym;
    int          underrun_cnt;
    int          max_level;

    // Slot timing: posedges counted since reset release; a slot edge is
    // every DIV-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        logic        is_slot;
        logic        has_data;
        logic [31:0] e;
        if (!rst_n) begin
            check("rst_data", odata, 32'h0);
            check("rst_valid", {31'b0, ovalid}, 32'h0);
            check("rst_underrun", {31'b0, underrun}, 32'h0);
            check("rst_ready", {31'b0, ready}, 32'h0);
            check("rst_level", 32'(level), 32'h0);
            exp_q.delete();
            m_lfsr       = 'h7F;
            m_prev_i     = 1'b0;
            m_prev_q     = 1'b0;
            started      = 1'b0;
            pending_xfer = 1'b0;
            last_data    = 32'h0;
            xfer_edge    = -100;
            n_real       = 0;
            underrun_cnt = 0;
        end else begin
            if (pending_xfer) check("ready_after_xfer", {31'b0, ready}, 32'h0);
            pending_xfer = 1'b0;

            is_slot = (edge_n > 0) && (edge_n % DIV == 0);
            if (is_slot) begin
                // A just-transferred word has not reached the buffer yet on
                // its transfer edge and the edge after.
                has_data = (exp_q.size() > 0) &&
                           !(((edge_n == xfer_edge) || (edge_n == xfer_edge + 1)) &&
                             (exp_q.size() == SYMS));
                if (has_data) begin
                    e = exp_q.pop_front();
                    check("slot_valid", {31'b0, ovalid}, 32'h1);
                    check("slot_underrun", {31'b0, underrun}, 32'h0);
                    check("slot_data", odata, e);
                    if (n_real == 0) first_sym = odata;
                    if (n_real == 1) second_sym = odata;
                    n_real++;
                    started   = 1'b1;
                    last_data = e;
                end else if (started) begin
                    check("idle_valid", {31'b0, ovalid}, 32'h1);
                    check("idle_underrun", {31'b0, underrun}, 32'h1);
                    check("idle_data", odata, 32'h0);
                    underrun_cnt++;
                    last_data = 32'h0;
                end else begin
                    check("pre_valid", {31'b0, ovalid}, 32'h0);
                    check("pre_underrun", {31'b0, underrun}, 32'h0);
                    check("pre_data", odata, last_data);
                end
            end else begin
                check("gap_valid", {31'b0, ovalid}, 32'h0);
                check("gap_underrun", {31'b0, underrun}, 32'h0);
                check("hold_data", odata, last_data);
            end

            check("level_bound", {31'b0, (int'(level) <= DEPTH)}, 32'h1);
            if (int'(level) > max_level) max_level = int'(level);

            if (valid && ready) begin
                xfer_edge    = edge_n + 1;
                pending_xfer = 1'b1;
                model_push(data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [W-1:0] w);
        int guard = 0;
        @(posedge clk);
        #1;
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = W'($urandom);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        data      = '0;
        max_level = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_rise", {31'b0, ready}, 32'h1);

        // Word 0x00 from reset, then let the buffer run dry.
        send_word(8'h00);
        drain("drain_00");
        check("first_00", first_sym, 32'hE000E000);
`ifdef DSSS_QPSK_DIFF_EN
        check("second_00_diff", second_sym, 32'h20002000);
`endif
        repeat (3 * DIV) @(negedge clk);
        check("underrun_seen", {31'b0, (underrun_cnt != 0)}, 32'h1);

        // Word 0xFF from reset.
        apply_reset();
        send_word(8'hFF);
        drain("drain_ff");
        check("first_ff", first_sym, 32'h20002000);

        // Back-to-back words fill the buffer and stall spreading.
        apply_reset();
        max_level = 0;
        for (int i = 0; i < 3; i++) send_word(W'($urandom));
        drain("drain_b2b");
        check("b2b_count", 32'(n_real), 32'(3 * SYMS));
        check("b2b_full", 32'(max_level), 32'(DEPTH));

        // Reset mid-word discards it and restarts the PN sequence.
        apply_reset();
        send_word(8'h00);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send_word(8'h00);
        drain("drain_midrst");
        check("first_after_rst", first_sym, 32'hE000E000);

        // Random words with random gaps.
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            send_word(W'($urandom));
            repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        drain("drain_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #2000000;
        check("global_timeout", 32'h0, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsss_qpsk_mapper.md
DSSS_QPSK_MAPPER -- requirements
Module: dsss_qpsk_mapper

Interface
REQ-001 SHALL have parameter SIZE_INPUT_BIT, default 8: width of the input data word, serialized MSB first.
REQ-002 SHALL have parameter SPREAD, default 24: chips per data bit; must be even, range 2..64.
REQ-003 SHALL have parameter DIVIDER, default 120: clock cycles per output symbol slot; must be at least 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: symbol buffer depth; must be a power of 2, minimum 4.
REQ-005 SHALL have parameter AMPLITUDE, default 16'sd8192: magnitude of the I/Q rail level.
REQ-006 SHALL have parameter PN_SEED, default 7'h7F: PN LFSR reset state; must be non-zero.
REQ-007 SHALL have the following ports, clock and reset first:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_data  in  SIZE_INPUT_BIT  input word.
- i_valid_input  in  1  i_data is valid.
- o_ready  out  1  block can accept a word.
- o_data  out  32  output symbol: {I[15:0], Q[15:0]}, two's complement.
- o_valid_output  out  1  one-cycle strobe marking the output symbol slot.
- o_underrun  out  1  one-cycle pulse marking a slot filled with the idle symbol.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current symbol buffer occupancy.

Function
REQ-008 SHALL transfer a word when i_valid_input & o_ready are high on a rising edge; i_data is ignored otherwise.
REQ-009 SHALL use a state machine with two states:
- IDLE: o_ready=1.
- SPREAD: o_ready=0.
- IDLE->SPREAD on transfer; SPREAD->IDLE after the last symbol of the word is written to the buffer.
REQ-010 In SPREAD, SHALL produce one symbol per cycle while the buffer is not full, and stall with no state change while it is full.
REQ-011 SHALL define PN: 7-bit LFSR; chip = state[6]; next = {state[5:0], state[6]^state[5]}.
- Advances exactly once per chip consumed.
- Free-running across words; not reloaded between words.
REQ-012 SHALL form each symbol from the current data bit b and two consecutive PN chips c0, c1:
- chipI = b^c0, chipQ = b^c1.
- Each bit yields SPREAD/2 symbols; each word yields SIZE_INPUT_BIT*SPREAD/2 symbols.
REQ-013 SHALL map chip 0 to +AMPLITUDE and chip 1 to -AMPLITUDE, independently per rail.
REQ-014 First buffer write SHALL occur on the cycle after transfer; a symbol written on a cycle where the buffer is full is forbidden.
REQ-015 SHALL run a slot counter 0..DIVIDER-1, wrapping, starting from 0 at reset release; a slot occurs when counter==DIVIDER-1.
REQ-016 At a slot with the buffer non-empty, SHALL pop one symbol and register it to o_data with o_valid_output=1 on the following cycle.
REQ-017 At a slot with the buffer empty, SHALL output o_data=0 and pulse o_underrun with o_valid_output, but only after the first real symbol has been output; before that, o_valid_output stays 0.
REQ-018 o_data SHALL hold its value between slots.
REQ-019 A simultaneous buffer write and slot pop SHALL leave o_fifo_level unchanged; occupancy never exceeds FIFO_DEPTH.

Reset
REQ-020 While i_reset=0, SHALL clear all state asynchronously:
- state=IDLE, LFSR=PN_SEED, slot counter=0, buffer empty, started flag cleared.
- Outputs: o_data=0, o_valid_output=0, o_underrun=0, o_fifo_level=0, o_ready=0.
REQ-021 o_ready SHALL rise on the first rising edge after reset release.
REQ-022 Reset asserted mid-word SHALL discard the word and all buffered symbols.

Configuration
REQ-023 With DSSS_QPSK_DIFF_EN defined, SHALL apply per-rail differential encoding before mapping:
- txI = chipI ^ prevI, txQ = chipQ ^ prevQ.
- prevI/prevQ reset to 0 and update on every buffer write.
REQ-024 Without DSSS_QPSK_DIFF_EN, SHALL map chipI/chipQ directly, and no prev registers SHALL exist.

Verification (SPREAD=2, DIVIDER=4, FIFO_DEPTH=16, SIZE_INPUT_BIT=8, macro off unless stated)
REQ-025 Word 0x00 after reset -> 8 symbols; first output o_data=32'hE000E000.
REQ-026 Word 0xFF after reset -> first output o_data=32'h20002000; slots exactly 4 cycles apart.
REQ-027 Three back-to-back words -> o_ready low on the cycle after each transfer; buffer reaches 16 and SPREAD stalls; no symbol is lost; 24 symbols are output in order.
REQ-028 One word, then no input -> after 8 valid symbols, the next slot gives o_data=0, o_underrun=1, o_valid_output=1.
REQ-029 Reset pulsed during the 5th symbol of a word -> outputs return to 0 and the LFSR restarts at 7'h7F; the next 0x00 word again yields 32'hE000E000 first.
REQ-030 With DSSS_QPSK_DIFF_EN defined, word 0x00 -> first symbol 32'hE000E000, second symbol 32'h20002000.
